rcv_read_seq_ctrl: RTL
======================

RCV_READ_SEQ_CTRL -- requirements
Module: rcv_read_seq_ctrl

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 1023, max mem_clk cycles in DRAIN without a FIFO pop before abort.
REQ-002 Parameter: LEN_WIDTH, default 8, width of word-count fields.
REQ-003 mem_clk  input  1  single clock; all logic on rising edge.
REQ-004 reset_n  input  1  synchronous, active-low reset, sampled on mem_clk rising edge.
REQ-005 rd_req  input  1  one-cycle read request pulse, honoured only in IDLE.
REQ-006 rd_len  input  LEN_WIDTH  number of 16-bit words to read, sampled with rd_req.
REQ-007 rd_dummy  input  5  dummy cycles before capture, sampled with rd_req.
REQ-008 rd_abort  input  1  abort current transfer.
REQ-009 down_ready  input  1  downstream can accept one word next cycle.
REQ-010 rcv_dqfifo_empty  input  1  receive DQ FIFO empty.
REQ-011 rcv_dqfifo_almost_full_sync  input  1  receive DQ FIFO almost full, already synchronised.
REQ-012 rcv_dq_fifo_flush_done  input  1  flush completion pulse.
REQ-013 rcv_dqfifo_dout  input  16  FIFO read data, valid the cycle after rcv_dqfifo_rd_en.
REQ-014 start_read  output  1  capture window enable to receive interface.
REQ-015 rcv_dq_fifo_flush_en  output  1  one-cycle flush request pulse.
REQ-016 rcv_dqfifo_rd_en  output  1  FIFO pop (combinational).
REQ-017 rd_data  output  16  equals rcv_dqfifo_dout.
REQ-018 rd_data_valid  output  1  rd_data valid this cycle; rd_last  output  1  final word of transfer.
REQ-019 rd_busy  output  1  state != IDLE; rd_done  output  1  one-cycle completion pulse.
REQ-020 rd_err  output  2  status valid with rd_done: bit0 abort/timeout, bit1 almost-full seen.

Function
REQ-021 States: IDLE, PRE_FLUSH, DUMMY, READ, DRAIN, POST_FLUSH, DONE; encoding free.
REQ-022 IDLE: rd_req with rd_len != 0 latches rd_len, rd_dummy, clears err flags, pulses rcv_dq_fifo_flush_en one cycle, -> PRE_FLUSH; rd_req with rd_len == 0 ignored.
REQ-023 PRE_FLUSH: wait rcv_dq_fifo_flush_done; -> DUMMY if latched dummy != 0 else -> READ.
REQ-024 DUMMY: 5-bit down-counter loaded with dummy, decrements per cycle; -> READ the cycle it reads 1.
REQ-025 READ: start_read = 1; issue counter increments each READ cycle; -> DRAIN when issue count reaches latched rd_len (start_read high exactly rd_len cycles).
REQ-026 rcv_dqfifo_rd_en = (READ or DRAIN) & !rcv_dqfifo_empty & down_ready & (pop count < rd_len).
REQ-027 rd_data_valid = rcv_dqfifo_rd_en delayed one cycle; rd_last = rd_data_valid & this word is number rd_len.
REQ-028 DRAIN: -> DONE the cycle after last pop (rd_last asserted); idle counter clears on each pop, -> POST_FLUSH with rd_err[0]=1 at TIMEOUT_CYCLES.
REQ-029 rcv_dqfifo_almost_full_sync high in READ or DRAIN sets sticky rd_err[1]; transfer continues.
REQ-030 rd_abort in PRE_FLUSH..DRAIN: start_read low next cycle, rd_en low, rd_err[0]=1, pulse flush, -> POST_FLUSH; rd_abort in IDLE/DONE/POST_FLUSH ignored.
REQ-031 POST_FLUSH: wait rcv_dq_fifo_flush_done -> DONE.
REQ-032 DONE: rd_done = 1 one cycle, rd_err held until next accepted rd_req, -> IDLE.
REQ-033 Counters LEN_WIDTH bits, never wrap (saturate at rd_len); rd_abort and rd_req same cycle in IDLE: rd_req wins.

Reset
REQ-034 reset_n low at a rising edge: state IDLE, all counters 0, all outputs 0 (rd_data follows input), regardless of transfer in progress; no flush issued by reset.

Verification
REQ-035 rd_req, rd_len=4, rd_dummy=0, FIFO fills, down_ready=1 -> one flush pulse, start_read high 4 cycles, 4 rd_data_valid, rd_last on 4th, rd_done, rd_err=0.
REQ-036 rd_dummy=3 -> start_read rises exactly 3 cycles after PRE_FLUSH exit.
REQ-037 down_ready toggling 1/0 with rd_len=8 -> no pop while down_ready=0, exactly 8 valid words, rd_last on 8th.
REQ-038 FIFO stays empty in DRAIN, TIMEOUT_CYCLES=16 -> flush pulse after 16 cycles, rd_done with rd_err=01.
REQ-039 rd_abort mid-READ -> start_read low next cycle, flush pulse, rd_done after flush_done, rd_err[0]=1; almost_full pulse in READ -> rd_err[1]=1.
REQ-040 reset_n low mid-DRAIN -> next cycle rd_busy=0, start_read=0, rd_done=0; rd_len=0 request -> no activity.

Source files
------------

// File: rtl/rcv_read_seq_ctrl.sv
// rcv_read_seq_ctrl: sequences one DRAM read burst on the receive side.
// It flushes the DQ FIFO, waits out the dummy cycles, opens the capture
// window for rd_len cycles, then drains the FIFO to the downstream port.
// Aborts and drain timeouts finish with a second flush. Every path ends
// with a one-cycle rd_done that carries the sticky error status.
//
// Downstream handshake: down_ready high in cycle N means the consumer can
// take one word in cycle N+1. A FIFO pop is issued in cycle N only when
// down_ready is high in that cycle. The popped word appears in cycle N+1 as
// rd_data with rd_data_valid, and it cannot be stalled. rd_last marks
// word number rd_len.
module rcv_read_seq_ctrl #(
  parameter int TIMEOUT_CYCLES = 1023,
  parameter int LEN_WIDTH      = 8
) (
  input  logic                 mem_clk,
  input  logic                 reset_n,
  input  logic                 rd_req,
  input  logic [LEN_WIDTH-1:0] rd_len,
  input  logic [4:0]           rd_dummy,
  input  logic                 rd_abort,
  input  logic                 down_ready,
  input  logic                 rcv_dqfifo_empty,
  input  logic                 rcv_dqfifo_almost_full_sync,
  input  logic                 rcv_dq_fifo_flush_done,
  input  logic [15:0]          rcv_dqfifo_dout,
  output logic                 start_read,
  output logic                 rcv_dq_fifo_flush_en,
  output logic                 rcv_dqfifo_rd_en,
  output logic [15:0]          rd_data,
  output logic                 rd_data_valid,
  output logic                 rd_last,
  output logic                 rd_busy,
  output logic                 rd_done,
  output logic [1:0]           rd_err
);

  // The idle counter only has to reach TIMEOUT_CYCLES-1.
  localparam int IDLE_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [IDLE_W-1:0]    IDLE_LIMIT = IDLE_W'(TIMEOUT_CYCLES - 1);
  localparam logic [LEN_WIDTH-1:0] LEN_ONE    = LEN_WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE_FLUSH,
    S_DUMMY,
    S_READ,
    S_DRAIN,
    S_POST_FLUSH,
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [LEN_WIDTH-1:0] len_q;
  logic [4:0]           dummy_q;
  logic [4:0]           dummy_cnt_q;
  logic [LEN_WIDTH-1:0] issue_cnt_q;
  logic [LEN_WIDTH-1:0] pop_cnt_q;
  logic [IDLE_W-1:0]    idle_cnt_q;
  logic [1:0]           err_q;
  logic                 flush_q, flush_d;
  logic                 valid_q;
  logic                 last_q;

  logic accept;
  logic in_xfer;
  logic abort_hit;
  logic pop;
  logic drain_done;
  logic timeout_hit;

  // Qualify requests, aborts and FIFO pops from the current state.
  always_comb begin
    accept      = (state_q == S_IDLE) && rd_req && (rd_len != '0);
    in_xfer     = (state_q == S_READ) || (state_q == S_DRAIN);
    abort_hit   = rd_abort && ((state_q == S_PRE_FLUSH) || (state_q == S_DUMMY) ||
                               (state_q == S_READ) || (state_q == S_DRAIN));
    pop         = in_xfer && !rd_abort && !rcv_dqfifo_empty && down_ready &&
                  (pop_cnt_q < len_q);
    // The last word either shows up now or was already delivered while
    // the burst was still in READ.
    drain_done  = last_q || ((pop_cnt_q == len_q) && !valid_q);
    timeout_hit = (state_q == S_DRAIN) && !drain_done && !pop &&
                  (idle_cnt_q == IDLE_LIMIT);
  end

  // Next-state logic and the flush request, which is registered to give a clean pulse.
  always_comb begin
    state_d = state_q;
    flush_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_PRE_FLUSH;
          flush_d = 1'b1;
        end
      end
      S_PRE_FLUSH: begin
        if (rcv_dq_fifo_flush_done) state_d = (dummy_q != '0) ? S_DUMMY : S_READ;
      end
      S_DUMMY: begin
        if (dummy_cnt_q <= 5'd1) state_d = S_READ;
      end
      S_READ: begin
        if (issue_cnt_q >= (len_q - LEN_ONE)) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (drain_done) begin
          state_d = S_DONE;
        end else if (timeout_hit) begin
          state_d = S_POST_FLUSH;
          flush_d = 1'b1;
        end
      end
      S_POST_FLUSH: begin
        if (rcv_dq_fifo_flush_done) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // An abort overrides any other transition of an active transfer.
    if (abort_hit) begin
      state_d = S_POST_FLUSH;
      flush_d = 1'b1;
    end
  end

  // State register and flush pulse. Reset issues no flush.
  always_ff @(posedge mem_clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      flush_q <= flush_d;
    end
  end

  // Latch the request parameters and run the dummy, issue, pop and idle counters.
  always_ff @(posedge mem_clk) begin
    if (!reset_n) begin
      len_q       <= '0;
      dummy_q     <= '0;
      dummy_cnt_q <= '0;
      issue_cnt_q <= '0;
      pop_cnt_q   <= '0;
      idle_cnt_q  <= '0;
    end else begin
      if (accept) begin
        len_q   <= rd_len;
        dummy_q <= rd_dummy;
      end

      if ((state_q == S_PRE_FLUSH) && (state_d == S_DUMMY)) begin
        dummy_cnt_q <= dummy_q;
      end else if ((state_q == S_DUMMY) && (dummy_cnt_q != '0)) begin
        dummy_cnt_q <= dummy_cnt_q - 5'd1;
      end

      if (accept) begin
        issue_cnt_q <= '0;
      end else if ((state_q == S_READ) && (issue_cnt_q != len_q)) begin
        issue_cnt_q <= issue_cnt_q + LEN_ONE;
      end

      if (accept) begin
        pop_cnt_q <= '0;
      end else if (pop) begin
        pop_cnt_q <= pop_cnt_q + LEN_ONE;
      end

      if ((state_q != S_DRAIN) || pop) begin
        idle_cnt_q <= '0;
      end else if (idle_cnt_q != IDLE_LIMIT) begin
        idle_cnt_q <= idle_cnt_q + IDLE_W'(1);
      end
    end
  end

  // FIFO read data is one cycle behind the pop, so valid and last follow the pop.
  always_ff @(posedge mem_clk) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= pop;
      last_q  <= pop && (pop_cnt_q == (len_q - LEN_ONE));
    end
  end

  // Sticky status. It is cleared only when the next request is accepted.
  always_ff @(posedge mem_clk) begin
    if (!reset_n) begin
      err_q <= 2'b00;
    end else if (accept) begin
      err_q <= 2'b00;
    end else begin
      if (abort_hit || timeout_hit)               err_q[0] <= 1'b1;
      if (in_xfer && rcv_dqfifo_almost_full_sync) err_q[1] <= 1'b1;
    end
  end

  assign start_read           = (state_q == S_READ);
  assign rcv_dq_fifo_flush_en = flush_q;
  assign rcv_dqfifo_rd_en     = pop;
  assign rd_data              = rcv_dqfifo_dout;
  assign rd_data_valid        = valid_q;
  assign rd_last              = last_q;
  assign rd_busy              = (state_q != S_IDLE);
  assign rd_done              = (state_q == S_DONE);
  assign rd_err               = err_q;

endmodule
